// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the FSM state encoding, next-pc select encoding, reset defaults
// and the payload struct for the instruction handed to decode.
package fetch_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  // Next-pc source
  typedef enum logic [1:0] {
    PC_SEL_HOLD     = 2'd0,
    PC_SEL_INC      = 2'd1,
    PC_SEL_REDIRECT = 2'd2
  } pc_sel_e;

  // Instruction payload presented to decode
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_inst_t;

endpackage : fetch_unit_pkg

// File: rtl/fetch_pc_gen.sv
// Next-pc selection for the fetch unit.
// Ports:
//   pc_cur      current pc register value
//   pc_sel      hold / increment / redirect
//   redirect_pc redirect target (low two bits ignored, word aligned)
//   pc_next_c   combinational next pc
module fetch_pc_gen
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc_cur,
  input  pc_sel_e         pc_sel,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next_c
);

  // pc+4 wraps naturally at 2^32; redirect targets are forced word aligned
  always_comb begin
    pc_next_c = pc_cur;
    case (pc_sel)
      PC_SEL_INC:      pc_next_c = pc_cur + XLEN'(4);
      PC_SEL_REDIRECT: pc_next_c = redirect_pc & ~XLEN'(3);
      default:         pc_next_c = pc_cur;
    endcase
  end

endmodule : fetch_pc_gen

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit.
// Issues one word read at a time, holds the returned instruction until
// decode takes it, and handles redirects from execute by discarding any
// in-flight response that belongs to the old path.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   req_valid/req_ready/req_addr      instruction-memory request
//   rsp_valid/rsp_data/rsp_err        instruction-memory response
//   redirect_valid/redirect_pc        taken branch/jump from execute
//   inst_valid/inst_ready/inst/inst_pc/inst_fault   decode handshake
//   opcode/funct3/funct7              slices of the held instruction
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [XLEN-1:0]     req_addr,
  input  logic                rsp_valid,
  input  logic [XLEN-1:0]     rsp_data,
  input  logic                rsp_err,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [XLEN-1:0]     inst,
  output logic [XLEN-1:0]     inst_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT3_W-1:0] funct3,
  output logic                funct7,
  output logic                inst_fault
);

  localparam fetch_inst_t INST_RESET = '{word: NOP_INST, pc: RESET_PC, fault: 1'b0};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  fetch_inst_t     inst_q, inst_d;
  pc_sel_e         pc_sel;

  fetch_pc_gen u_pc_gen (
    .pc_cur      (pc_q),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc),
    .pc_next_c   (pc_d)
  );

  // Next-state, drop tracking, instruction capture and pc source
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    pc_sel  = PC_SEL_HOLD;

    // Redirect wins over every other pc update outside IDLE
    if (redirect_valid && (state_q != ST_IDLE)) begin
      pc_sel = PC_SEL_REDIRECT;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (req_ready) begin
          state_d = ST_WAIT;
          // Request just issued targets the old path if a redirect lands now
          drop_d  = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (rsp_valid) begin
          drop_d  = 1'b0;
          state_d = ST_REQ;
          if (!drop_q && !redirect_valid) begin
            inst_d.word  = rsp_err ? NOP_INST : rsp_data;
            inst_d.pc    = pc_q;
            inst_d.fault = rsp_err;
            state_d      = ST_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          state_d = ST_REQ;
        end else if (inst_ready) begin
          state_d = ST_REQ;
          pc_sel  = PC_SEL_INC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered views of the next state
    req_valid_d  = (state_d == ST_REQ);
    inst_valid_d = (state_d == ST_HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= INST_RESET;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_addr   = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q.word;
  assign inst_pc    = inst_q.pc;
  assign inst_fault = inst_q.fault;

  // Decode fields straight off the held instruction
  assign opcode = inst_q.word[6:0];
  assign funct3 = inst_q.word[14:12];
  assign funct7 = inst_q.word[30];

endmodule : fetch_unit
